// File: rtl/zap_wb_arbiter_pkg.sv
// ============================================================================
// Module   : zap_wb_arbiter_pkg
// Purpose  : Shared arbiter state encodings, Wishbone CTI constants, helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package zap_wb_arbiter_pkg;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_GNT_C = 2'd1;
   localparam logic [1:0] c_ST_GNT_D = 2'd2;

   localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
   localparam logic [2:0] c_CTI_BURST   = 3'b010;
   localparam logic [2:0] c_CTI_EOB     = 3'b111;

   function automatic logic wb_req(input logic cyc, input logic stb);
      return cyc & stb;
   endfunction

endpackage

`default_nettype wire

// File: rtl/zap_wb_arbiter_if.sv
// ============================================================================
// Module   : zap_wb_arbiter_if
// Purpose  : One Wishbone B3 link; master drives the request, slave responds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface zap_wb_arbiter_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic        ack;
   logic [31:0] dat_r;

   modport master (output cyc, stb, we, sel, cti, adr, dat_w,
                   input  ack, dat_r);
   modport slave  (input  cyc, stb, we, sel, cti, adr, dat_w,
                   output ack, dat_r);
endinterface

`default_nettype wire

// File: rtl/zap_wb_mux2.sv
// ============================================================================
// Module   : zap_wb_mux2
// Purpose  : Combinational steering of two Wishbone masters onto one link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zap_wb_mux2 (
   input  logic [1:0]              i_gnt,
   zap_wb_arbiter_if.slave         c_wb,
   zap_wb_arbiter_if.slave         d_wb,
   zap_wb_arbiter_if.master        m_wb
);

   always_comb begin
      m_wb.cyc   = 1'b0;
      m_wb.stb   = 1'b0;
      m_wb.we    = 1'b0;
      m_wb.sel   = 4'd0;
      m_wb.cti   = 3'd0;
      m_wb.adr   = 32'd0;
      m_wb.dat_w = 32'd0;
      c_wb.ack   = 1'b0;
      d_wb.ack   = 1'b0;
      // Read data is broadcast; only the qualifying ACK is steered.
      c_wb.dat_r = m_wb.dat_r;
      d_wb.dat_r = m_wb.dat_r;
      case (i_gnt)
         2'b01: begin
            m_wb.cyc   = c_wb.cyc;
            m_wb.stb   = c_wb.stb;
            m_wb.we    = c_wb.we;
            m_wb.sel   = c_wb.sel;
            m_wb.cti   = c_wb.cti;
            m_wb.adr   = c_wb.adr;
            m_wb.dat_w = c_wb.dat_w;
            c_wb.ack   = m_wb.ack;
         end
         2'b10: begin
            m_wb.cyc   = d_wb.cyc;
            m_wb.stb   = d_wb.stb;
            m_wb.we    = d_wb.we;
            m_wb.sel   = d_wb.sel;
            m_wb.cti   = d_wb.cti;
            m_wb.adr   = d_wb.adr;
            m_wb.dat_w = d_wb.dat_w;
            d_wb.ack   = m_wb.ack;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/zap_wb_arbiter.sv
// ============================================================================
// Module   : zap_wb_arbiter
// Purpose  : Two-master Wishbone arbiter (code/data side), grant held per CYC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zap_wb_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1,
   parameter bit D_PRIORITY  = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   zap_wb_arbiter_if.slave   c_wb,
   zap_wb_arbiter_if.slave   d_wb,
   zap_wb_arbiter_if.master  m_wb,
   output logic [1:0]        o_gnt
);
   import zap_wb_arbiter_pkg::*;

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [1:0] w_gnt;
   logic       r_last_c;
   logic       w_c_req;
   logic       w_d_req;
   logic       w_pick_d;

   assign w_c_req  = wb_req(c_wb.cyc, c_wb.stb);
   assign w_d_req  = wb_req(d_wb.cyc, d_wb.stb);
   // r_last_c=1 means C was served last, so D wins the next tie.
   assign w_pick_d = ROUND_ROBIN ? r_last_c : D_PRIORITY;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state  <= c_ST_IDLE;
         r_last_c <= D_PRIORITY;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == c_ST_IDLE && w_state_nxt == c_ST_GNT_C)
            r_last_c <= 1'b1;
         else if (r_state == c_ST_IDLE && w_state_nxt == c_ST_GNT_D)
            r_last_c <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_c_req && w_d_req)
               w_state_nxt = w_pick_d ? c_ST_GNT_D : c_ST_GNT_C;
            else if (w_c_req)
               w_state_nxt = c_ST_GNT_C;
            else if (w_d_req)
               w_state_nxt = c_ST_GNT_D;
         end
         c_ST_GNT_C: if (!c_wb.cyc) w_state_nxt = c_ST_IDLE;
         c_ST_GNT_D: if (!d_wb.cyc) w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_gnt = 2'b00;
      case (r_state)
         c_ST_GNT_C: w_gnt = 2'b01;
         c_ST_GNT_D: w_gnt = 2'b10;
         default:    w_gnt = 2'b00;
      endcase
   end

   assign o_gnt = w_gnt;

   zap_wb_mux2 u_mux (
      .i_gnt (w_gnt),
      .c_wb  (c_wb),
      .d_wb  (d_wb),
      .m_wb  (m_wb)
   );

endmodule

`default_nettype wire

// File: tb/tb_zap_wb_arbiter.sv
// ============================================================================
// Module   : tb_zap_wb_arbiter
// Purpose  : Scenario bench for zap_wb_arbiter with an ACK-routing scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zap_wb_arbiter;
   import zap_wb_arbiter_pkg::*;

   typedef struct packed {
      logic        is_d;
      logic [31:0] dat;
   } sb_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] gnt;
   int         errors;
   int         checks;
   sb_t        sb_q[$];

   zap_wb_arbiter_if c_if ();
   zap_wb_arbiter_if d_if ();
   zap_wb_arbiter_if m_if ();

   zap_wb_arbiter #(.ROUND_ROBIN(1'b1), .D_PRIORITY(1'b1)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .c_wb      (c_if),
      .d_wb      (d_if),
      .m_wb      (m_if),
      .o_gnt     (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_c(input logic cyc, input logic stb, input logic [2:0] cti,
                          input logic [31:0] adr);
      c_if.cyc = cyc; c_if.stb = stb; c_if.we = 1'b0; c_if.sel = 4'hF;
      c_if.cti = cti; c_if.adr = adr; c_if.dat_w = adr ^ 32'h5555_0000;
   endtask

   task automatic drive_d(input logic cyc, input logic stb, input logic [2:0] cti,
                          input logic [31:0] adr);
      d_if.cyc = cyc; d_if.stb = stb; d_if.we = 1'b1; d_if.sel = 4'h3;
      d_if.cti = cti; d_if.adr = adr; d_if.dat_w = adr ^ 32'hAAAA_0000;
   endtask

   // Adapter returns one ACK; the scoreboard expects it at master exp_d.
   task automatic ack_beat(input logic exp_d, input logic [31:0] dat);
      sb_t exp_e;
      sb_t got;
      m_if.ack   = 1'b1;
      m_if.dat_r = dat;
      sb_q.push_back({exp_d, dat});
      #1;
      exp_e = sb_q.pop_front();
      checks++;
      if (c_if.ack === d_if.ack) begin
         errors++;
         $display("FAIL ack_route: c_ack=%b d_ack=%b required one-hot to %s",
                  c_if.ack, d_if.ack, exp_e.is_d ? "D" : "C");
      end else begin
         got.is_d = d_if.ack;
         got.dat  = d_if.ack ? d_if.dat_r : c_if.dat_r;
         if (got !== exp_e) begin
            errors++;
            $display("FAIL ack_data: got master=%b dat=%h required master=%b dat=%h",
                     got.is_d, got.dat, exp_e.is_d, exp_e.dat);
         end
      end
      m_if.ack = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive_c(1'b1, 1'b1, c_CTI_CLASSIC, 32'h0000_0C00);
      drive_d(1'b1, 1'b1, c_CTI_CLASSIC, 32'h0000_0D00);
      m_if.ack = 1'b1; m_if.dat_r = 32'h1111_2222;
      step; step;
      checks++;
      if ({m_if.cyc, m_if.stb, m_if.we, m_if.sel, m_if.cti, m_if.adr, m_if.dat_w} !== 43'd0) begin
         errors++;
         $display("FAIL reset_bus: cyc=%b adr=%h required all zero", m_if.cyc, m_if.adr);
      end
      checks++;
      if (gnt !== 2'b00 || c_if.ack !== 1'b0 || d_if.ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_gnt: gnt=%b c_ack=%b d_ack=%b required 00/0/0",
                  gnt, c_if.ack, d_if.ack);
      end
      m_if.ack = 1'b0;
      rst_n = 1'b1;
      step;
      checks++;
      if (gnt !== 2'b10 || m_if.adr !== 32'h0000_0D00) begin
         errors++;
         $display("FAIL reset_first_gnt: gnt=%b adr=%h required 10/00000d00", gnt, m_if.adr);
      end
      drive_c(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      drive_d(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      step; step;
   endtask

   task automatic test_single_c;
      drive_c(1'b1, 1'b1, c_CTI_CLASSIC, 32'h0000_0100);
      step;
      checks++;
      if (gnt !== 2'b01 || m_if.adr !== 32'h0000_0100 || m_if.cyc !== 1'b1) begin
         errors++;
         $display("FAIL single_c_gnt: gnt=%b adr=%h cyc=%b required 01/00000100/1",
                  gnt, m_if.adr, m_if.cyc);
      end
      ack_beat(1'b0, 32'hDEAD_BEEF);
      step;
      drive_c(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      step;
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("FAIL single_c_release: gnt=%b required 00", gnt);
      end
   endtask

   task automatic test_burst_d;
      logic [2:0] cti_tab [4];
      cti_tab[0] = c_CTI_BURST; cti_tab[1] = c_CTI_BURST;
      cti_tab[2] = c_CTI_BURST; cti_tab[3] = c_CTI_EOB;
      drive_c(1'b1, 1'b1, c_CTI_CLASSIC, 32'h0000_0C40);
      drive_d(1'b1, 1'b1, cti_tab[0], 32'h0000_2000);
      step;
      for (int i = 0; i < 4; i++) begin
         drive_d(1'b1, 1'b1, cti_tab[i], 32'h0000_2000 + 32'(i * 4));
         #1;
         checks++;
         if (gnt !== 2'b10 || m_if.cti !== cti_tab[i] ||
             m_if.adr !== 32'h0000_2000 + 32'(i * 4) || m_if.we !== 1'b1) begin
            errors++;
            $display("FAIL burst_beat%0d: gnt=%b cti=%b adr=%h required 10/%b/%h",
                     i, gnt, m_if.cti, m_if.adr, cti_tab[i], 32'h0000_2000 + 32'(i * 4));
         end
         ack_beat(1'b1, 32'hB000_0000 + 32'(i));
         step;
      end
      drive_d(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      step;
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("FAIL burst_bubble: gnt=%b required 00", gnt);
      end
      step;
      checks++;
      if (gnt !== 2'b01 || m_if.adr !== 32'h0000_0C40) begin
         errors++;
         $display("FAIL burst_c_after: gnt=%b adr=%h required 01/00000c40", gnt, m_if.adr);
      end
      ack_beat(1'b0, 32'hC0C0_C0C0);
      step;
      drive_c(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      step; step;
   endtask

   task automatic test_round_robin;
      logic exp_d;
      drive_c(1'b1, 1'b1, c_CTI_CLASSIC, 32'h0000_0C80);
      drive_d(1'b1, 1'b1, c_CTI_CLASSIC, 32'h0000_0D80);
      for (int i = 0; i < 4; i++) begin
         exp_d = (i % 2 == 0);
         step;
         checks++;
         if (gnt !== {exp_d, ~exp_d}) begin
            errors++;
            $display("FAIL rr_gnt%0d: gnt=%b required %b", i, gnt, {exp_d, ~exp_d});
         end
         ack_beat(exp_d, 32'hA000_0000 + 32'(i));
         step;
         if (exp_d) drive_d(1'b0, 1'b0, c_CTI_CLASSIC, 32'h0000_0D80);
         else       drive_c(1'b0, 1'b0, c_CTI_CLASSIC, 32'h0000_0C80);
         step;
         if (exp_d) drive_d(1'b1, 1'b1, c_CTI_CLASSIC, 32'h0000_0D80);
         else       drive_c(1'b1, 1'b1, c_CTI_CLASSIC, 32'h0000_0C80);
         #1;
         checks++;
         if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL rr_bubble%0d: gnt=%b required 00", i, gnt);
         end
      end
      drive_c(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      drive_d(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      step; step;
   endtask

   task automatic test_stray_ack;
      m_if.ack = 1'b1; m_if.dat_r = 32'h0000_1234;
      #1;
      checks++;
      if (c_if.ack !== 1'b0 || d_if.ack !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack: c_ack=%b d_ack=%b required 0/0", c_if.ack, d_if.ack);
      end
      step;
      checks++;
      if (gnt !== 2'b00 || m_if.cyc !== 1'b0) begin
         errors++;
         $display("FAIL stray_idle: gnt=%b cyc=%b required 00/0", gnt, m_if.cyc);
      end
      m_if.ack = 1'b0;
   endtask

   task automatic test_mid_burst_reset;
      drive_c(1'b1, 1'b1, c_CTI_BURST, 32'h0000_3000);
      step;
      ack_beat(1'b0, 32'hE000_0001);
      step;
      drive_c(1'b1, 1'b1, c_CTI_BURST, 32'h0000_3004);
      rst_n = 1'b0;
      ack_beat(1'b0, 32'hE000_0002);
      step;
      m_if.ack = 1'b1;
      #1;
      checks++;
      if (m_if.cyc !== 1'b0 || gnt !== 2'b00 || c_if.ack !== 1'b0 || d_if.ack !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: cyc=%b gnt=%b c_ack=%b required 0/00/0",
                  m_if.cyc, gnt, c_if.ack);
      end
      m_if.ack = 1'b0;
      drive_c(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      rst_n = 1'b1;
      step;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      drive_c(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      drive_d(1'b0, 1'b0, c_CTI_CLASSIC, 32'd0);
      m_if.ack   = 1'b0;
      m_if.dat_r = 32'd0;
      test_reset;
      test_single_c;
      test_burst_d;
      test_round_robin;
      test_stray_ack;
      test_mid_burst_reset;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
